instr_fetch_unit: RTL and testbench

Fetch stage of the lab CPU: owns the program counter, drives the word-indexed instruction ROM's byte address, and latches the returned word into an instruction register. Supports free-run and single-step (board button) modes, plus stall, branch and jump redirection from the downstream decode/execute stage. Detects jump-to-self and out-of-range PCs and halts.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/instr_fetch_unit_step_edge.sv | 18 +
 rtl/instr_fetch_unit.sv | 97 +++++++++
 tb/tb_instr_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types, defaults and next-PC arithmetic for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_0000;
  localparam int unsigned ROM_WORDS_DEFAULT = 32;

  // Jump wins over branch; branch offset is a signed word count relative to pc+4.
  function automatic logic [31:0] next_pc(
    input logic [31:0] pc_plus4,
    input logic        jump,
    input logic [25:0] jump_index,
    input logic        branch_taken,
    input logic [15:0] branch_offset
  );
    logic [31:0] boff;
    boff = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    if (jump)
      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
    else if (branch_taken)
      next_pc = pc_plus4 + boff;
    else
      next_pc = pc_plus4;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_step_edge.sv
// Registered rising-edge detector for the single-step request level.
module step_edge (
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic step_rise
);

  logic step_q;

  always_ff @(posedge clk) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step;
  end

  assign step_rise = step & ~step_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, ROM addressing, instruction register, run/step control,
// branch/jump redirection, jump-to-self halt and out-of-range fault.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
  parameter int unsigned ROM_WORDS = ROM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        retire,
  output logic [15:0] retired_cnt,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] PC_LIMIT = 32'(ROM_WORDS * 4);

  state_t      state, state_nx;
  logic        step_rise;
  logic [31:0] npc;
  logic        self_jump;
  logic        out_of_range;

  step_edge u_step_edge (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .step_rise (step_rise)
  );

  assign rom_addr     = pc;
  assign pc_plus4     = pc + 32'd4;
  assign npc          = next_pc(pc_plus4, jump, jump_index, branch_taken, branch_offset);
  assign self_jump    = jump && (npc == pc);
  assign out_of_range = (npc >= PC_LIMIT);

  always_comb begin
    state_nx    = state;
    instr_valid = 1'b0;
    retire      = 1'b0;
    case (state)
      IDLE:  if (run || step_rise) state_nx = FETCH;
      FETCH: state_nx = EXEC;
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          retire = 1'b1;
          if (self_jump || out_of_range) state_nx = HALT;
          else if (run)                  state_nx = FETCH;
          else                           state_nx = IDLE;
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
    // Reset masks the EXEC outputs so no retire is seen while rst is held.
    if (rst) begin
      instr_valid = 1'b0;
      retire      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= PC_RESET;
      instr       <= '0;
      retired_cnt <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == FETCH) instr <= rom_data;
      if (retire) begin
        pc          <= npc;
        retired_cnt <= retired_cnt + 16'd1;
        if (self_jump)         halted <= 1'b1;
        else if (out_of_range) fault  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected retirements queued by stimulus,
// popped and checked by an independent monitor on every retire pulse.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, run, step, stall;
  logic        branch_taken, jump;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] rom_addr, rom_data, instr, pc, pc_plus4;
  logic        instr_valid, retire, halted, fault;
  logic [15:0] retired_cnt;

  logic [31:0] rom [0:31];

  // Decoder stand-in: one-shot branch at bsel_pc, jump-to-self at 0x44.
  logic        bsel_en;
  logic [31:0] bsel_pc;
  logic [15:0] bsel_off;
  logic [15:0] bsel_cnt;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_cyc = -100;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rom_data      = (rom_addr < 32'd128) ? rom[rom_addr[6:2]] : 32'h0;
  assign branch_taken  = bsel_en && instr_valid && (pc == bsel_pc) && (retired_cnt == bsel_cnt);
  assign branch_offset = bsel_off;
  assign jump          = instr_valid && (pc == 32'h44);
  assign jump_index    = 26'h11;

  instr_fetch_unit #(
    .PC_RESET  (32'h0000_0000),
    .ROM_WORDS (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .step          (step),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .instr         (instr),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .instr_valid   (instr_valid),
    .retire        (retire),
    .retired_cnt   (retired_cnt),
    .halted        (halted),
    .fault         (fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] p, input int gap);
    exp_t e;
    e.pc    = p;
    e.instr = rom[p[6:2]];
    e.gap   = gap;
    q.push_back(e);
  endtask

  task automatic wait_stop(input int limit);
    int k;
    k = 0;
    while (!(halted || fault) && k < limit) begin
      tick(1);
      k++;
    end
    chk("stop_reached", {31'd0, halted | fault}, 32'd1);
  endtask

  task automatic do_reset;
    run  = 1'b0;
    step = 1'b0;
    rst  = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Monitor: every retire pulse must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (retire) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_retire: pc %h instr %h with empty queue", pc, instr);
        end else begin
          e = q.pop_front();
          chk("retire_pc", pc, e.pc);
          chk("retire_instr", instr, e.instr);
          if (e.gap != 0) chk("retire_gap", 32'(cyc - last_cyc), 32'(e.gap));
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h2000_0000 | 32'(i);
    rom[0]  = 32'h2008_0000;
    rom[1]  = 32'h200d_0050;
    rom[16] = 32'h1d20_fff9;
    rom[17] = 32'h0800_0011;
    bsel_en  = 1'b0;
    bsel_pc  = 32'h40;
    bsel_off = 16'h0;
    bsel_cnt = 16'd16;
    stall    = 1'b0;
    run      = 1'b0;
    step     = 1'b0;
    rst      = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Stall in EXEC, then reset while stalled.
    stall = 1'b1;
    step  = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_pc", pc, 32'h0);
      tick(1);
    end
    chk("stall_instr", instr, 32'h2008_0000);
    rst = 1'b1;
    tick(3);
    rst   = 1'b0;
    step  = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_cnt", {16'd0, retired_cnt}, 32'd0);
    chk("rst_flags", {30'd0, halted, fault}, 32'd0);
    chk("rst_rom_addr", rom_addr, 32'h0);
    tick(2);
    chk("idle_stays", {31'd0, instr_valid}, 32'd0);

    // Step mode: held level gives exactly one instruction.
    push(32'h0, 0);
    step = 1'b1;
    tick(2);
    @(negedge clk);
    chk("step_exec_valid", {31'd0, instr_valid}, 32'd1);
    tick(8);
    chk("step_cnt", {16'd0, retired_cnt}, 32'd1);
    chk("step_pc", pc, 32'h4);

    // Second step edge arriving during a stalled EXEC is dropped.
    step  = 1'b0;
    stall = 1'b1;
    tick(1);
    step = 1'b1;
    tick(2);
    step = 1'b0;
    tick(1);
    step = 1'b1;
    tick(1);
    push(32'h4, 0);
    stall = 1'b0;
    tick(6);
    chk("drop_cnt", {16'd0, retired_cnt}, 32'd2);
    chk("drop_pc", pc, 32'h8);

    // Free-run whole program to the jump-to-self at 0x44.
    do_reset();
    for (int i = 0; i < 18; i++) push(32'(i * 4), (i == 0) ? 0 : 2);
    run = 1'b1;
    wait_stop(200);
    chk("free_halted", {31'd0, halted}, 32'd1);
    chk("free_fault", {31'd0, fault}, 32'd0);
    chk("free_pc", pc, 32'h44);
    chk("free_cnt", {16'd0, retired_cnt}, 32'd18);
    chk("free_instr", instr, 32'h0800_0011);
    for (int i = 0; i < 4; i++) begin
      step = 1'b1;
      tick(2);
      step = 1'b0;
      run  = ~run;
      tick(2);
    end
    chk("halt_pc", pc, 32'h44);
    chk("halt_cnt", {16'd0, retired_cnt}, 32'd18);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("free_drained", 32'(q.size()), 32'd0);

    // Branch at 0x40 back to 0x28 (taken once), then on to the halt.
    do_reset();
    bsel_en  = 1'b1;
    bsel_off = 16'hfff9;
    for (int i = 0; i < 17; i++) push(32'(i * 4), (i == 0) ? 0 : 2);
    for (int a = 32'h28; a <= 32'h44; a += 4) push(32'(a), 2);
    run = 1'b1;
    wait_stop(300);
    chk("br_halted", {31'd0, halted}, 32'd1);
    chk("br_pc", pc, 32'h44);
    chk("br_cnt", {16'd0, retired_cnt}, 32'd25);
    chk("br_drained", 32'(q.size()), 32'd0);

    // Branch to 0x80 leaves the ROM: fault, pc kept at the bad target.
    do_reset();
    bsel_off = 16'h000f;
    for (int i = 0; i < 17; i++) push(32'(i * 4), (i == 0) ? 0 : 2);
    run = 1'b1;
    wait_stop(200);
    tick(4);
    chk("flt_fault", {31'd0, fault}, 32'd1);
    chk("flt_halted", {31'd0, halted}, 32'd0);
    chk("flt_pc", pc, 32'h80);
    chk("flt_rom_addr", rom_addr, 32'h80);
    chk("flt_cnt", {16'd0, retired_cnt}, 32'd17);
    chk("flt_valid", {31'd0, instr_valid}, 32'd0);
    chk("flt_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
